// File: rtl/conv_layer.sv
// ---------------------------------------------------------------------------
// conv_layer
//
// Streaming 3x3 valid-padding convolution over a signed 8-bit IN_W x IN_H
// feature map delivered in raster order.  Each result is arithmetically
// shifted right by SHIFT, saturated to signed 8 bits and emitted through a
// one-deep output register, giving an (IN_W-2) x (IN_H-2) output map.
//
// Optional feature: define CONV_RELU_EN to clamp negative results to 0.
//
// Ports
//   clk, rst          : clock (rising edge) and asynchronous active-high reset
//   start             : one-cycle pulse, begins a frame from IDLE or DONE
//   done              : high in DONE until the next accepted start
//   busy              : high while a frame is in RUN or DRAIN
//   w_we/w_addr/w_data: kernel tap write (taps 0..8 row-major, IDLE/DONE only)
//   in_valid/in_ready/in_data    : input pixel handshake
//   out_valid/out_ready/out_data : output pixel handshake
// ---------------------------------------------------------------------------
module conv_layer #(
    parameter int IN_W  = 8,
    parameter int IN_H  = 8,
    parameter int SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       done,
    output logic       busy,
    input  logic       w_we,
    input  logic [3:0] w_addr,
    input  logic [7:0] w_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);

    localparam int CW    = $clog2(IN_W);
    localparam int RW    = $clog2(IN_H);
    localparam int TOTAL = (IN_W - 2) * (IN_H - 2);
    localparam int OW    = $clog2(TOTAL + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [OW-1:0]     out_cnt;
    logic signed [7:0] kernel [0:8];

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2, indexed by column.
    logic signed [7:0] lb0 [0:IN_W-1];
    logic signed [7:0] lb1 [0:IN_W-1];

    // Only the two older window columns are stored; the newest column is
    // formed from the line buffers and the incoming pixel, so the result can
    // be registered on the same acceptance that completes the window.
    logic signed [7:0] win_a [0:2];
    logic signed [7:0] win_b [0:2];
    logic signed [7:0] new_col [0:2];
    logic signed [7:0] taps [0:8];

    logic signed [15:0] prod [0:8];
    logic signed [19:0] acc;
    logic signed [19:0] shifted;
    logic signed [7:0]  sat;
    logic [7:0]         result;

    logic accept;
    logic out_fire;
    logic last_pix;
    logic win_done;
    logic kernel_open;

    assign done        = (state == DONE);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign in_ready    = (state == RUN) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign last_pix    = (row == RW'(IN_H - 1)) && (col == CW'(IN_W - 1));
    assign win_done    = (row >= RW'(2)) && (col >= CW'(2));
    assign kernel_open = (state == IDLE) || (state == DONE);

    // Assemble the window that will exist after the current pixel is shifted
    // in, then multiply-accumulate, shift (floor) and saturate it.
    always_comb begin
        new_col[0] = lb1[col];
        new_col[1] = lb0[col];
        new_col[2] = in_data;
        for (int r = 0; r < 3; r++) begin
            taps[r*3 + 0] = win_a[r];
            taps[r*3 + 1] = win_b[r];
            taps[r*3 + 2] = new_col[r];
        end
        acc = '0;
        for (int k = 0; k < 9; k++) begin
            prod[k] = 16'(taps[k]) * 16'(kernel[k]);
            acc     = acc + 20'(prod[k]);
        end
        shifted = acc >>> SHIFT;
        if (shifted > 20'sd127) begin
            sat = 8'sd127;
        end else if (shifted < -20'sd128) begin
            sat = -8'sd128;
        end else begin
            sat = shifted[7:0];
        end
`ifdef CONV_RELU_EN
        result = sat[7] ? 8'd0 : sat;
`else
        result = sat;
`endif
    end

    // Pixel storage needs no reset: stale contents never reach the output
    // because a window only completes after two fresh rows have arrived.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_data;
            for (int r = 0; r < 3; r++) begin
                win_a[r] <= win_b[r];
                win_b[r] <= new_col[r];
            end
        end
    end

    // Control, kernel registers, counters and the output register.  The
    // frame-start clears sit after the datapath updates so they take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < 9; k++) begin
                kernel[k] <= '0;
            end
        end else begin
            if (w_we && kernel_open) begin
                for (int k = 0; k < 9; k++) begin
                    if (w_addr == 4'(k)) begin
                        kernel[k] <= w_data;
                    end
                end
            end

            if (accept) begin
                if (col == CW'(IN_W - 1)) begin
                    col <= '0;
                    row <= last_pix ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (accept && win_done) begin
                out_valid <= 1'b1;
                out_data  <= result;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (out_fire) begin
                out_cnt <= out_cnt + 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        col       <= '0;
                        row       <= '0;
                        out_cnt   <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                    end
                end
                RUN: begin
                    if (accept && last_pix) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire && (out_cnt == OW'(TOTAL - 1))) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer.sv
// ---------------------------------------------------------------------------
// tb_conv_layer
//
// Directed bench for conv_layer with default parameters (8x8 in, 6x6 out,
// SHIFT=4).  Expected values are hand-derived per frame; the ReLU variant of
// each expectation is selected when CONV_RELU_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv_layer;

`ifdef CONV_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       start;
    logic       done;
    logic       busy;
    logic       w_we;
    logic [3:0] w_addr;
    logic [7:0] w_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;

    conv_layer dut (
        .clk       (clock),
        .rst       (reset),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int relu(input int x);
        return (RELU && x < 0) ? 0 : x;
    endfunction

    // mode 0: ramp pixel r*8+c-32 (= index-32); mode 1: constant pixel
    function automatic int pixel(input int mode, input int konst, input int idx);
        return (mode == 0) ? idx - 32 : konst;
    endfunction

    // Writes every tap with allTaps except the centre tap (4).
    task automatic setKernel(input int allTaps, input int centre);
        for (int k = 0; k < 9; k++) begin
            w_we   = 1'b1;
            w_addr = 4'(k);
            w_data = 8'((k == 4) ? centre : allTaps);
            @(negedge clock);
        end
        w_we = 1'b0;
    endtask

    // Runs one full frame.  mode 0 expects the identity result (centre pixel
    // of each window); mode 1 expects expConst for every output.  stallAt>=0
    // holds out_ready low for 5 cycles at that output, and during the stall
    // issues a kernel write and a start pulse that must both be ignored.
    task automatic applyStimulus(input string tag, input int mode, input int konst,
                                 input int expConst, input int stallAt);
        int in_idx;
        int out_idx;
        int cyc;
        int stall_left;
        int exp_val;
        bit stalled;
        logic signed [7:0] held;
        in_idx = 0; out_idx = 0; cyc = 0; stall_left = 0; stalled = 0; held = '0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput({tag, " in_ready after start"}, int'(in_ready), 1);
        checkOutput({tag, " busy after start"}, int'(busy), 1);
        while (out_idx < 36 && cyc < 1000) begin
            w_we  = 1'b0;
            start = 1'b0;
            if (!stalled && stallAt >= 0 && out_idx == stallAt && out_valid) begin
                stalled    = 1'b1;
                stall_left = 5;
                held       = $signed(out_data);
            end
            out_ready = (stall_left == 0);
            if (stall_left == 3) begin
                w_we   = 1'b1;
                w_addr = 4'd4;
                w_data = 8'd0;
            end
            if (stall_left == 2) start = 1'b1;
            in_valid = (in_idx < 64);
            in_data  = 8'(pixel(mode, konst, in_idx));
            #1;
            if (stall_left > 0) begin
                checkOutput({tag, " stall in_ready"}, int'(in_ready), 0);
                checkOutput({tag, " stall out_valid"}, int'(out_valid), 1);
                checkOutput({tag, " stall out_data held"}, int'($signed(out_data)), int'(held));
                stall_left--;
            end
            if (out_valid && out_ready) begin
                exp_val = (mode == 0)
                        ? relu((out_idx / 6 + 1) * 8 + (out_idx % 6 + 1) - 32)
                        : expConst;
                checkOutput($sformatf("%s out[%0d]", tag, out_idx),
                            int'($signed(out_data)), exp_val);
                if (out_idx == 35) checkOutput({tag, " done before last"}, int'(done), 0);
                out_idx++;
            end
            if (in_valid && in_ready) in_idx++;
            cyc++;
            @(negedge clock);
        end
        w_we = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checkOutput({tag, " output count"}, out_idx, 36);
        checkOutput({tag, " input count"}, in_idx, 64);
        checkOutput({tag, " done after last"}, int'(done), 1);
        checkOutput({tag, " busy after last"}, int'(busy), 0);
        checkOutput({tag, " out_valid after last"}, int'(out_valid), 0);
    endtask

    // Feeds 20 ramp pixels of a frame, then resets asynchronously mid-frame.
    task automatic applyResetMidFrame();
        int fed;
        int cyc;
        fed = 0; cyc = 0;
        start = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        out_ready = 1'b1;
        while (fed < 20 && cyc < 200) begin
            in_valid = 1'b1;
            in_data  = 8'(fed - 32);
            #1;
            if (in_valid && in_ready) fed++;
            cyc++;
            @(negedge clock);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("midframe pixels fed", fed, 20);
        checkOutput("midframe busy", int'(busy), 1);
        checkOutput("midframe out_data", int'($signed(out_data)), relu(-22));
        reset = 1'b1;
        #2;
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst in_ready", int'(in_ready), 0);
        checkOutput("rst out_valid", int'(out_valid), 0);
        checkOutput("rst out_data", int'(out_data), 0);
        checkOutput("rst done", int'(done), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset in_ready", int'(in_ready), 0);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset out_data", int'(out_data), 0);

        setKernel(0, 16);
        applyStimulus("identity", 0, 0, 0, -1);
        setKernel(16, 16);
        applyStimulus("all16 x10", 1, 10, relu(90), -1);
        setKernel(127, 127);
        applyStimulus("sat pos", 1, 127, relu(127), -1);
        setKernel(-128, -128);
        applyStimulus("sat neg", 1, 127, relu(-128), -1);
        setKernel(0, -16);
        applyStimulus("neg centre", 1, 5, relu(-5), -1);
        setKernel(0, 1);
        applyStimulus("floor", 1, -1, relu(-1), -1);
        setKernel(0, 16);
        applyStimulus("stall", 0, 0, 0, 7);

        applyResetMidFrame();
        applyStimulus("kernel cleared", 1, 50, 0, -1);
        setKernel(0, 16);
        applyStimulus("identity after rst", 0, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
